// File: rtl/illegal_trap_ctrl_pkg.sv
// Shared definitions for the synchronous-exception sequencer: FSM state type,
// machine-mode cause codes and a word-alignment helper.
package illegal_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        SAVE     = 2'd2,
        REDIRECT = 2'd3
    } trap_state_t;

    localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M       = 32'd11;

    // Clear the two low bits so a PC/address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// Trap CSR storage: mepc, mcause and mtval. SAVE-state write from the trap
// sequencer takes precedence over the software mepc write port.
// Optional macro ILLEGAL_TRAP_MTVAL_EN builds the mtval register; without it
// mtval reads as constant zero.
import illegal_trap_ctrl_pkg::*;

module trap_csr_regs #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_MEPC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            save_we,
    input  logic [XLEN-1:0] save_pc,
    input  logic [XLEN-1:0] save_cause,
    input  logic [XLEN-1:0] save_mtval,
    input  logic            sw_we,
    input  logic [XLEN-1:0] sw_wdata,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval
);

    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;

    // mepc: trap save wins over software write; both stored word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            mepc_q <= RESET_MEPC;
        end else if (save_we) begin
            mepc_q <= word_align(save_pc);
        end else if (sw_we) begin
            mepc_q <= word_align(sw_wdata);
        end
    end

    // mcause: only written by the trap save.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcause_q <= '0;
        end else if (save_we) begin
            mcause_q <= save_cause;
        end
    end

`ifdef ILLEGAL_TRAP_MTVAL_EN
    logic [XLEN-1:0] mtval_q;

    // mtval: only written by the trap save.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtval_q <= '0;
        end else if (save_we) begin
            mtval_q <= save_mtval;
        end
    end

    assign mtval = mtval_q;
`else
    logic unused_save_mtval;
    assign unused_save_mtval = ^save_mtval;
    assign mtval = '0;
`endif

    assign mepc   = mepc_q;
    assign mcause = mcause_q;

endmodule

// File: rtl/illegal_trap_ctrl.sv
// Synchronous-exception sequencer. Accepts illegal/ebreak/ecall/mret events
// from decode, stalls and flushes the pipe, saves trap CSRs and redirects
// fetch to mtvec (trap) or mepc (mret).
// Optional macro ILLEGAL_TRAP_MTVAL_EN enables mtval capture.
import illegal_trap_ctrl_pkg::*;

module illegal_trap_ctrl #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_MEPC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid_i,
    input  logic [XLEN-1:0] dec_pc_i,
    input  logic [31:0]     dec_instr_i,
    input  logic            dec_illegal_i,
    input  logic            dec_ecall_i,
    input  logic            dec_ebreak_i,
    input  logic            dec_mret_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            sw_mepc_we_i,
    input  logic [XLEN-1:0] sw_wdata_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            csr_we_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            busy_o
);

    trap_state_t     state_q, state_d;
    logic            evt;
    logic            evt_mret;
    logic [XLEN-1:0] evt_cause;
    logic [XLEN-1:0] evt_mtval;
    logic            sw_we;
    logic [XLEN-1:0] pend_pc_q;
    logic [XLEN-1:0] pend_cause_q;
    logic            pend_mret_q;
    logic [XLEN-1:0] save_mtval;

    assign evt = (state_q == IDLE) && dec_valid_i &&
                 (dec_illegal_i || dec_ebreak_i || dec_ecall_i || dec_mret_i);

    // Priority encode the strobes: illegal > ebreak > ecall > mret.
    always_comb begin
        evt_mret  = 1'b0;
        evt_cause = '0;
        evt_mtval = '0;
        if (dec_illegal_i) begin
            evt_cause = CAUSE_ILLEGAL_INSTR;
            evt_mtval = dec_instr_i;
        end else if (dec_ebreak_i) begin
            evt_cause = CAUSE_BREAKPOINT;
            evt_mtval = dec_pc_i;
        end else if (dec_ecall_i) begin
            evt_cause = CAUSE_ECALL_M;
        end else begin
            evt_mret = 1'b1;
        end
    end

    // A coinciding event drops the software mepc write.
    assign sw_we = sw_mepc_we_i && (state_q == IDLE) && !evt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending event capture on the IDLE edge that accepts an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_pc_q    <= '0;
            pend_cause_q <= '0;
            pend_mret_q  <= 1'b0;
        end else if (evt) begin
            pend_pc_q    <= dec_pc_i;
            pend_cause_q <= evt_cause;
            pend_mret_q  <= evt_mret;
        end
    end

`ifdef ILLEGAL_TRAP_MTVAL_EN
    logic [XLEN-1:0] pend_mtval_q;

    // Pending mtval capture alongside the other pending fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_mtval_q <= '0;
        end else if (evt) begin
            pend_mtval_q <= evt_mtval;
        end
    end

    assign save_mtval = pend_mtval_q;
`else
    logic unused_evt_mtval;
    assign unused_evt_mtval = ^evt_mtval;
    assign save_mtval = '0;
`endif

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        stall_o       = 1'b0;
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        csr_we_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt) state_d = FLUSH;
            end
            FLUSH: begin
                stall_o = 1'b1;
                flush_o = 1'b1;
                state_d = pend_mret_q ? REDIRECT : SAVE;
            end
            SAVE: begin
                stall_o  = 1'b1;
                csr_we_o = 1'b1;
                state_d  = REDIRECT;
            end
            REDIRECT: begin
                redirect_o = 1'b1;
                // Synchronous traps always use the mtvec base, even when vectored.
                redirect_pc_o = pend_mret_q ? mepc_o : word_align(mtvec_i);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

    trap_csr_regs #(
        .XLEN       (XLEN),
        .RESET_MEPC (RESET_MEPC)
    ) u_trap_csr_regs (
        .clk        (clk),
        .rst        (rst),
        .save_we    (csr_we_o),
        .save_pc    (pend_pc_q),
        .save_cause (pend_cause_q),
        .save_mtval (save_mtval),
        .sw_we      (sw_we),
        .sw_wdata   (sw_wdata_i),
        .mepc       (mepc_o),
        .mcause     (mcause_o),
        .mtval      (mtval_o)
    );

endmodule

// File: tb/tb_illegal_trap_ctrl.sv
// Directed self-checking bench for illegal_trap_ctrl. Expected mtval depends
// on whether ILLEGAL_TRAP_MTVAL_EN is defined for the build.
module tb_illegal_trap_ctrl;

`ifdef ILLEGAL_TRAP_MTVAL_EN
    localparam bit MTVAL_EN = 1'b1;
`else
    localparam bit MTVAL_EN = 1'b0;
`endif
    localparam logic [31:0] RST_MEPC = 32'hDEAD_BEE0;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_illegal, dec_ecall, dec_ebreak, dec_mret;
    logic [31:0] dec_pc, dec_instr, mtvec, sw_wdata;
    logic        sw_mepc_we;
    logic        stall, flush, redirect, csr_we, busy;
    logic [31:0] redirect_pc, mepc, mcause, mtval;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    illegal_trap_ctrl #(
        .XLEN       (32),
        .RESET_MEPC (RST_MEPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dec_valid_i   (dec_valid),
        .dec_pc_i      (dec_pc),
        .dec_instr_i   (dec_instr),
        .dec_illegal_i (dec_illegal),
        .dec_ecall_i   (dec_ecall),
        .dec_ebreak_i  (dec_ebreak),
        .dec_mret_i    (dec_mret),
        .mtvec_i       (mtvec),
        .sw_mepc_we_i  (sw_mepc_we),
        .sw_wdata_i    (sw_wdata),
        .stall_o       (stall),
        .flush_o       (flush),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc),
        .csr_we_o      (csr_we),
        .mepc_o        (mepc),
        .mcause_o      (mcause),
        .mtval_o       (mtval),
        .busy_o        (busy)
    );

    task automatic clear_inputs();
        dec_valid   = 1'b0;
        dec_illegal = 1'b0;
        dec_ecall   = 1'b0;
        dec_ebreak  = 1'b0;
        dec_mret    = 1'b0;
        dec_pc      = '0;
        dec_instr   = '0;
        sw_mepc_we  = 1'b0;
        sw_wdata    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        mtvec = 32'h200;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, stall, flush, redirect, csr_we} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000", {busy, stall, flush, redirect, csr_we});
        else passed++;
        total++;
        if (mepc !== RST_MEPC) $display("FAIL reset_mepc: got %h want %h", mepc, RST_MEPC);
        else passed++;
        total++;
        if ({mcause, mtval, redirect_pc} !== 96'h0)
            $display("FAIL reset_csr: mcause %h mtval %h rpc %h want 0", mcause, mtval, redirect_pc);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] exp_mtval;
        exp_mtval = MTVAL_EN ? 32'hFFFF_FFFF : 32'h0;
        @(negedge clk);
        mtvec = 32'h200; dec_valid = 1'b1; dec_illegal = 1'b1;
        dec_pc = 32'h100; dec_instr = 32'hFFFF_FFFF;
        #1;
        total++;
        if ({busy, stall, flush} !== 3'b000) $display("FAIL ill_c0: got %b want 000", {busy, stall, flush});
        else passed++;
        @(negedge clk);
        clear_inputs();
        total++;
        if ({busy, stall, flush, csr_we, redirect} !== 5'b11100)
            $display("FAIL ill_c1: got %b want 11100", {busy, stall, flush, csr_we, redirect});
        else passed++;
        total++;
        if (mcause !== 32'h0) $display("FAIL ill_c1_precause: got %h want 0", mcause);
        else passed++;
        @(negedge clk);
        total++;
        if ({busy, stall, flush, csr_we, redirect} !== 5'b11010)
            $display("FAIL ill_c2: got %b want 11010", {busy, stall, flush, csr_we, redirect});
        else passed++;
        @(negedge clk);
        total++;
        if ({busy, stall, csr_we, redirect} !== 4'b1001 || redirect_pc !== 32'h200)
            $display("FAIL ill_c3: got %b pc %h want 1001 pc 00000200",
                     {busy, stall, csr_we, redirect}, redirect_pc);
        else passed++;
        total++;
        if (mepc !== 32'h100 || mcause !== 32'd2 || mtval !== exp_mtval)
            $display("FAIL ill_csr: got %h/%h/%h want 00000100/00000002/%h", mepc, mcause, mtval, exp_mtval);
        else passed++;
        @(negedge clk);
        total++;
        if ({busy, redirect} !== 2'b00 || redirect_pc !== 32'h0)
            $display("FAIL ill_c4: got %b pc %h want 00 pc 0", {busy, redirect}, redirect_pc);
        else passed++;
    endtask

    task automatic test_ebreak();
        logic [31:0] exp_mtval;
        exp_mtval = MTVAL_EN ? 32'h40 : 32'h0;
        @(negedge clk);
        mtvec = 32'h301; dec_valid = 1'b1; dec_ebreak = 1'b1;
        dec_pc = 32'h40; dec_instr = 32'h0010_0073;
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        total++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h300)
            $display("FAIL ebreak_redirect: got %b %h want 1 00000300", redirect, redirect_pc);
        else passed++;
        total++;
        if (mepc !== 32'h40 || mcause !== 32'd3 || mtval !== exp_mtval)
            $display("FAIL ebreak_csr: got %h/%h/%h want 00000040/00000003/%h", mepc, mcause, mtval, exp_mtval);
        else passed++;
        @(negedge clk);
        mtvec = 32'h200;
    endtask

    task automatic test_priority();
        logic [31:0] exp_mtval;
        exp_mtval = MTVAL_EN ? 32'h0000_0073 : 32'h0;
        @(negedge clk);
        dec_valid = 1'b1; dec_illegal = 1'b1; dec_ecall = 1'b1;
        dec_pc = 32'h80; dec_instr = 32'h0000_0073;
        @(negedge clk);
        // Second event while in FLUSH must be ignored.
        clear_inputs();
        dec_valid = 1'b1; dec_ebreak = 1'b1; dec_pc = 32'h500;
        #1;
        total++;
        if (busy !== 1'b1 || flush !== 1'b1) $display("FAIL prio_busy: got %b%b want 11", busy, flush);
        else passed++;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        total++;
        if (mepc !== 32'h80 || mcause !== 32'd2 || mtval !== exp_mtval)
            $display("FAIL prio_csr: got %h/%h/%h want 00000080/00000002/%h", mepc, mcause, mtval, exp_mtval);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || mcause !== 32'd2)
            $display("FAIL prio_ignored: busy %b mcause %h want 0 00000002", busy, mcause);
        else passed++;
    endtask

    task automatic test_sw_mret();
        bit saw_we = 1'b0;
        @(negedge clk);
        sw_mepc_we = 1'b1; sw_wdata = 32'h1237;
        @(negedge clk);
        clear_inputs();
        total++;
        if (mepc !== 32'h1234) $display("FAIL sw_mepc: got %h want 00001234", mepc);
        else passed++;
        // MRET with a coinciding (dropped) software write.
        dec_valid = 1'b1; dec_mret = 1'b1; dec_pc = 32'h900;
        sw_mepc_we = 1'b1; sw_wdata = 32'h5550;
        #1;
        saw_we |= csr_we;
        @(negedge clk);
        clear_inputs();
        saw_we |= csr_we;
        total++;
        if ({busy, flush, redirect} !== 3'b110) $display("FAIL mret_c1: got %b want 110", {busy, flush, redirect});
        else passed++;
        @(negedge clk);
        saw_we |= csr_we;
        total++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h1234 || stall !== 1'b0)
            $display("FAIL mret_c2: got %b %h stall %b want 1 00001234 0", redirect, redirect_pc, stall);
        else passed++;
        @(negedge clk);
        saw_we |= csr_we;
        total++;
        if (busy !== 1'b0 || mepc !== 32'h1234) $display("FAIL mret_c3: got %b %h want 0 00001234", busy, mepc);
        else passed++;
        total++;
        if (saw_we !== 1'b0) $display("FAIL mret_no_csr_we: got %b want 0", saw_we);
        else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dec_valid = 1'b1; dec_illegal = 1'b1; dec_pc = 32'h10; dec_instr = 32'h0;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        total++;
        if (csr_we !== 1'b1) $display("FAIL rstmid_save: got %b want 1", csr_we);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, redirect, csr_we} !== 3'b000 || mcause !== 32'h0 || mepc !== RST_MEPC)
            $display("FAIL rstmid_idle: got %b %h %h want 000 0 %h", {busy, redirect, csr_we}, mcause, mepc, RST_MEPC);
        else passed++;
        @(negedge clk);
        total++;
        if ({redirect, csr_we} !== 2'b00 || mcause !== 32'h0)
            $display("FAIL rstmid_after: got %b %h want 00 0", {redirect, csr_we}, mcause);
        else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mtvec = 32'h200; dec_valid = 1'b1; dec_ecall = 1'b1; dec_pc = 32'h207;
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        total++;
        if (redirect !== 1'b1 || mepc !== 32'h204 || mcause !== 32'd11 || mtval !== 32'h0)
            $display("FAIL b2b_first: got %b %h %h %h want 1 00000204 0000000b 0", redirect, mepc, mcause, mtval);
        else passed++;
        @(negedge clk);
        dec_valid = 1'b1; dec_ebreak = 1'b1; dec_pc = 32'h300;
        @(negedge clk);
        clear_inputs();
        total++;
        if (flush !== 1'b1) $display("FAIL b2b_accept: got %b want 1", flush);
        else passed++;
        repeat (2) @(negedge clk);
        total++;
        if (mepc !== 32'h300 || mcause !== 32'd3)
            $display("FAIL b2b_second: got %h %h want 00000300 00000003", mepc, mcause);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_ebreak();
        test_priority();
        test_sw_mret();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/illegal_trap_ctrl.md
# illegal_trap_ctrl

Synchronous-exception sequencer for the RV32 core. It sits beside the decode stage and consumes the decoder's illegal-instruction flag together with the ECALL, EBREAK and MRET strobes. On a trap it stalls and flushes the pipeline, writes mepc, mcause and mtval, and redirects fetch to mtvec. On MRET it flushes and redirects fetch to the saved mepc.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_MEPC, 32'h0000_0000, reset value of the internal mepc register.

Ports:
- clk  in  1  core clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- dec_valid_i  in  1  decode stage holds a valid instruction.
- dec_pc_i  in  XLEN  PC of the decode instruction.
- dec_instr_i  in  32  raw instruction word.
- dec_illegal_i  in  1  illegal-instruction flag from the decoder check.
- dec_ecall_i, dec_ebreak_i, dec_mret_i  in  1 each  system-instruction strobes.
- mtvec_i  in  XLEN  current mtvec from the CSR file.
- sw_mepc_we_i  in  1  software CSR write to mepc.
- sw_wdata_i  in  XLEN  data for the software mepc write.
- stall_o  out  1  freeze fetch/decode.
- flush_o  out  1  kill fetch, decode and execute contents.
- redirect_o  out  1  one-cycle PC load strobe.
- redirect_pc_o  out  XLEN  target PC for the load.
- csr_we_o  out  1  one-cycle write strobe for mepc/mcause/mtval.
- mepc_o, mcause_o, mtval_o  out  XLEN each  trap CSR values.
- busy_o  out  1  state is not IDLE.

## Operation
- States: IDLE, FLUSH, SAVE, REDIRECT.
- In IDLE, an event is dec_valid_i with any strobe set.
- Event priority: illegal > ebreak > ecall > mret; only the highest-priority strobe is acted on.
- Trap path is IDLE→FLUSH→SAVE→REDIRECT→IDLE.
  - The IDLE edge captures pc, instruction and cause into pending registers.
- MRET path is IDLE→FLUSH→REDIRECT→IDLE, and skips SAVE.
- mcause values:
  - illegal: 2, mtval = instruction.
  - ebreak: 3, mtval = pc.
  - ecall: 11, mtval = 0.
  - mcause bit 31 is always 0.
- SAVE: mepc ← pending pc & ~3, mcause/mtval ← pending values, csr_we_o=1.
- REDIRECT target:
  - trap: {mtvec_i[31:2],2'b00}. Synchronous traps always use the base, even in vectored mode.
  - MRET: mepc_o.
- Decode inputs are ignored outside IDLE.
- sw_mepc_we_i is honoured only in IDLE with no event that cycle; it writes sw_wdata_i & ~3. If an event coincides with the write, the event wins and the write is dropped.
- An MRET accepted in the same cycle as a dropped software write uses the old mepc.

## Timing
- Cycle 0: event sampled in IDLE. Outputs in that cycle are still IDLE values.
- Cycle 1 (FLUSH): stall_o=1, flush_o=1.
- Cycle 2, trap (SAVE): stall_o=1, csr_we_o=1.
  - mepc_o/mcause_o/mtval_o show the new values from cycle 3 on.
- Cycle 3, trap (REDIRECT): redirect_o=1, redirect_pc_o valid, stall_o=0.
  - Trap latency is 3 cycles from event to redirect.
- Cycle 2, MRET (REDIRECT): MRET latency is 2 cycles.
- Next cycle after REDIRECT: IDLE. A new event may be accepted there.
- busy_o=1 in FLUSH, SAVE and REDIRECT.
- redirect_pc_o is 0 when redirect_o=0.
- Reset values:
  - state=IDLE; all strobes, stall_o, flush_o and busy_o are 0.
  - mepc_o=RESET_MEPC, mcause_o=0, mtval_o=0, redirect_pc_o=0.
- Reset asserted mid-sequence returns to IDLE on the next edge. The redirect is abandoned and no csr_we_o is issued afterwards.
- Before a csr_we_o the CSR regs keep their pre-trap values.

## Configuration
- ILLEGAL_TRAP_MTVAL_EN:
  - Defined: mtval captured as above.
  - Undefined: mtval_o is constantly 0 and no mtval pending register is built. mcause/mepc behaviour is unchanged.

## Structure
- Shared package (core-wide package) holds:
  - the trap_state_t enum (IDLE, FLUSH, SAVE, REDIRECT);
  - cause constants CAUSE_ILLEGAL_INSTR=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11.
- One sub-module, trap_csr_regs: the mepc/mcause/mtval registers with the SAVE write and software mepc write ports. The FSM stays in the top module.

## Test plan
- Illegal instr 32'hFFFF_FFFF at pc 32'h100, mtvec 32'h200:
  - flush_o in cycle 1, csr_we_o in cycle 2, redirect_o in cycle 3 with pc 32'h200;
  - then mepc 32'h100, mcause 2, mtval 32'hFFFF_FFFF.
- EBREAK at 32'h40 with mtvec 32'h301:
  - redirect to 32'h300, mcause 3, mtval 32'h40.
- Illegal and ecall strobes together at 32'h80:
  - mcause 2; a second event in FLUSH is ignored (busy_o=1).
- Software write 32'h1237 to mepc, then MRET:
  - mepc_o 32'h1234; redirect at cycle 2 to 32'h1234; csr_we_o never asserted.
- rst pulsed in SAVE:
  - next cycle IDLE, no redirect_o, mcause_o=0, mepc_o=RESET_MEPC.
- Build without ILLEGAL_TRAP_MTVAL_EN, illegal at 32'h10:
  - mtval_o stays 0; mcause 2; mepc 32'h10.
